// File: rtl/univ_shift_register_pkg.sv
// rtl/univ_shift_register_pkg.sv - opcode and state definitions shared by the universal shift register
package univ_shift_pkg;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD  = 3'b001;
    localparam logic [2:0] OP_CLEAR = 3'b010;
    localparam logic [2:0] OP_SHL   = 3'b011;
    localparam logic [2:0] OP_SHR   = 3'b100;
    localparam logic [2:0] OP_ROL   = 3'b101;
    localparam logic [2:0] OP_ROR   = 3'b110;
    localparam logic [2:0] OP_ASR   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // NOP, LOAD and CLEAR finish on the start edge; everything else steps amt times.
    function automatic logic is_shift_op(input logic [2:0] op);
        return (op != OP_NOP) && (op != OP_LOAD) && (op != OP_CLEAR);
    endfunction

endpackage

// File: rtl/univ_shift_register_if.sv
// rtl/univ_shift_register_if.sv - command/data bundle between a controller and the shift register
interface univ_shift_register_if #(
    parameter int N  = 4,
    parameter int AW = 3
);
    logic          start;
    logic [2:0]    op;
    logic [AW-1:0] amt;
    logic [N-1:0]  D;
    logic          sin;
    logic [N-1:0]  Q;
    logic          sout_msb;
    logic          sout_lsb;
    logic          busy;
    logic          done;

    modport master (
        output start, op, amt, D, sin,
        input  Q, sout_msb, sout_lsb, busy, done
    );

    modport slave (
        input  start, op, amt, D, sin,
        output Q, sout_msb, sout_lsb, busy, done
    );
endinterface

// File: rtl/univ_shift_register_shift_step.sv
// rtl/univ_shift_register_shift_step.sv - one combinational shift/rotate step of the register value
module usr_shift_step
    import univ_shift_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] q,
    input  logic [2:0]   op,
    input  logic         sin,
    output logic [N-1:0] q_next
);

    always_comb begin
        q_next = q;
        case (op)
            OP_SHL:  q_next = {q[N-2:0], sin};
            OP_SHR:  q_next = {sin, q[N-1:1]};
            OP_ROL:  q_next = {q[N-2:0], q[N-1]};
            OP_ROR:  q_next = {q[0], q[N-1:1]};
            OP_ASR:  q_next = {q[N-1], q[N-1:1]};
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_register.sv
// rtl/univ_shift_register.sv - N-bit universal register with load/clear and multi-cycle shifts/rotates
module univ_shift_register
    import univ_shift_pkg::*;
#(
    parameter int N  = 4,
    parameter int AW = 3
) (
    input logic                   clk,
    input logic                   clr_n,
    univ_shift_register_if.slave  bus
);

    state_e        state_q, state_d;
    logic [N-1:0]  q_q, q_d;
    logic [AW-1:0] rem_q, rem_d;
    logic [2:0]    op_q, op_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [2:0]    step_op;
    logic [N-1:0]  step_q;

    // The start edge steps with the live opcode; RUN steps with the latched one.
    assign step_op = (state_q == ST_IDLE) ? bus.op : op_q;

    usr_shift_step #(.N(N)) u_step (
        .q      (q_q),
        .op     (step_op),
        .sin    (bus.sin),
        .q_next (step_q)
    );

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rem_d   = rem_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    rem_d   = '0;
                    state_d = ST_DONE;
                    if (bus.op == OP_LOAD) begin
                        q_d = bus.D;
                    end else if (bus.op == OP_CLEAR) begin
                        q_d = '0;
                    end else if (is_shift_op(bus.op) && (bus.amt != '0)) begin
                        q_d   = step_q;
                        rem_d = bus.amt - AW'(1);
                        if (bus.amt != AW'(1)) begin
                            state_d = ST_RUN;
                        end
                    end
                end
            end
            ST_RUN: begin
                q_d   = step_q;
                rem_d = rem_q - AW'(1);
                if (rem_q == AW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            rem_q   <= '0;
            op_q    <= OP_NOP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.Q        = q_q;
    assign bus.sout_msb = q_q[N-1];
    assign bus.sout_lsb = q_q[0];
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_univ_shift_register.sv
// tb/tb_univ_shift_register.sv - scoreboard bench for univ_shift_register
module tb_univ_shift_register;
    import univ_shift_pkg::*;

    logic clk;
    logic clr_n;

    univ_shift_register_if #(.N(4), .AW(3)) bus();

    univ_shift_register #(.N(4), .AW(3)) dut (
        .clk   (clk),
        .clr_n (clr_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0] q;
        int         cycles;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   bcnt     = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic issue(input logic [2:0] o, input logic [2:0] a, input logic [3:0] d,
                         input logic s, input logic push, input logic [3:0] eq, input int ec);
        exp_t e;
        if (push) begin
            e.q      = eq;
            e.cycles = ec;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op    = o;
        bus.amt   = a;
        bus.D     = d;
        bus.sin   = s;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!bus.done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_done_seen"}, bus.done, 1);
        if (bus.done) begin
            @(posedge clk); #1;
            check({name, "_idle_busy"}, bus.busy, 0);
            check({name, "_idle_done"}, bus.done, 0);
        end
    endtask

    // Monitor: pop an expectation at every done pulse and compare result and busy length.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!clr_n || !bus.busy) begin
                bcnt = 0;
            end else begin
                bcnt++;
                if (bus.done) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_done: got done with empty scoreboard, Q=%0h", bus.Q);
                    end else begin
                        e = sb.pop_front();
                        check("done_q", bus.Q, e.q);
                        check("busy_cycles", bcnt, e.cycles);
                    end
                end
            end
        end
    end

    initial begin
        clr_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = OP_NOP;
        bus.amt   = '0;
        bus.D     = '0;
        bus.sin   = 1'b0;
        #2;
        check("rst_q", bus.Q, 4'h0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        @(posedge clk); #1;
        clr_n = 1'b1;

        issue(OP_LOAD, 3'd0, 4'b1011, 1'b0, 1'b1, 4'b1011, 1);
        check("load_q_edge0", bus.Q, 4'b1011);
        check("load_done_edge0", bus.done, 1);
        wait_done("load");

        issue(OP_SHL, 3'd2, 4'b0000, 1'b1, 1'b1, 4'b1111, 2);
        check("shl_step1", bus.Q, 4'b0111);
        check("shl_step1_busy", bus.busy, 1);
        @(posedge clk); #1;
        check("shl_step2", bus.Q, 4'b1111);
        check("sout_msb", bus.sout_msb, 1);
        wait_done("shl");

        issue(OP_LOAD, 3'd0, 4'b1000, 1'b0, 1'b1, 4'b1000, 1);
        wait_done("load1000a");
        issue(OP_ROR, 3'd3, 4'b0000, 1'b1, 1'b1, 4'b0001, 3);
        wait_done("ror");
        check("sout_lsb", bus.sout_lsb, 1);

        issue(OP_LOAD, 3'd0, 4'b1000, 1'b0, 1'b1, 4'b1000, 1);
        wait_done("load1000b");
        issue(OP_ASR, 3'd2, 4'b0000, 1'b0, 1'b1, 4'b1110, 2);
        wait_done("asr");

        issue(OP_SHR, 3'd0, 4'b0101, 1'b1, 1'b1, 4'b1110, 1);
        wait_done("shr_amt0");

        issue(OP_LOAD, 3'd0, 4'b0001, 1'b0, 1'b1, 4'b0001, 1);
        wait_done("load0001");
        issue(OP_SHL, 3'd5, 4'b0000, 1'b0, 1'b1, 4'b0000, 5);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op    = OP_LOAD;
        bus.D     = 4'b1111;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done("shl5_ignored_start");

        issue(OP_LOAD, 3'd0, 4'b1011, 1'b0, 1'b1, 4'b1011, 1);
        wait_done("load_pre_abort");
        issue(OP_SHL, 3'd5, 4'b0000, 1'b0, 1'b0, 4'b0000, 0);
        @(posedge clk); #1;
        check("abort_busy_before", bus.busy, 1);
        check("abort_q_before", bus.Q, 4'b1100);
        #3;
        clr_n = 1'b0;
        #1;
        check("abort_q", bus.Q, 4'h0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        @(posedge clk); #1;
        clr_n = 1'b1;
        issue(OP_LOAD, 3'd0, 4'b0101, 1'b0, 1'b1, 4'b0101, 1);
        wait_done("load_after_abort");

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
